// File: rtl/cell_pos_reader_pkg.sv
// Shared constants and state encoding for the per-cell position reader.
package cell_pos_reader_pkg;

    localparam int unsigned RD_LAT      = 2;
    localparam int unsigned COORD_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_CNT   = 3'd1,
        WAIT_CNT = 3'd2,
        STREAM   = 3'd3,
        DRAIN    = 3'd4,
        FIN      = 3'd5
    } state_t;

endpackage

// File: rtl/cell_pos_reader_fifo.sv
// First-word-fall-through output FIFO holding {data, id, last} beats.
module pos_out_fifo #(
    parameter int unsigned WIDTH = 105,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_ok;

    // Wrap a pointer at DEPTH so non-power-of-two depths also work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign pop_ok   = pop && (count != '0);
    assign valid    = (count != '0);
    // Head word is zeroed while empty so a flushed FIFO presents all-zero outputs.
    assign pop_data = valid ? mem[rd_ptr] : '0;

    // Storage array; contents are meaningless while count says empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop keeps count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // The issuer's credit limit guarantees a push never lands on a full FIFO.
            assert (!(push && !pop_ok && (count == CNT_W'(DEPTH))));
        end
    end

endmodule

// File: rtl/cell_pos_reader.sv
// Read initiator for one cell position RAM: fetches the particle count at
// address 0, then streams particles 1..N through a credit-limited FIFO.
module cell_pos_reader
    import cell_pos_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 3 * COORD_WIDTH,
    parameter int unsigned PARTICLE_NUM = 220,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  count_err,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_rden,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_id,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned BEAT_W = DATA_WIDTH + ADDR_WIDTH + 1;
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CRED_W = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;
    localparam logic [ADDR_WIDTH-1:0] MAX_N = ADDR_WIDTH'(PARTICLE_NUM - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] n_count;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [RD_LAT-1:0]     pipe_v;
    logic [ADDR_WIDTH-1:0] pipe_id [RD_LAT];
    logic [FCNT_W-1:0]     fifo_count;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_valid;
    logic [BEAT_W-1:0]     fifo_wdata;
    logic [BEAT_W-1:0]     fifo_rdata;
    logic [CRED_W-1:0]     outstanding;
    logic                  can_issue;
    logic                  pipe_empty;
    logic [ADDR_WIDTH-1:0] cnt_raw;
    logic                  cnt_over;
    logic [ADDR_WIDTH-1:0] n_latch;

    // Count word decode with clamp to the RAM's particle capacity.
    assign cnt_raw  = ram_q[ADDR_WIDTH-1:0];
    assign cnt_over = (cnt_raw > MAX_N);
    assign n_latch  = cnt_over ? MAX_N : cnt_raw;

    // Only particle words enter the FIFO; the count word returns during WAIT_CNT.
    assign fifo_push  = pipe_v[RD_LAT-1] && ((state == STREAM) || (state == DRAIN));
    assign fifo_pop   = fifo_valid && out_ready;
    assign fifo_wdata = {ram_q, pipe_id[RD_LAT-1], (pipe_id[RD_LAT-1] == n_count)};
    assign pipe_empty = (pipe_v == '0) && !ram_rden;

    assign {out_data, out_id, out_last} = fifo_rdata;
    assign out_valid = fifo_valid;
    assign ram_wren  = 1'b0;

    // Credit: words that will occupy FIFO or pipe next cycle, before any new issue.
    always_comb begin
        outstanding = CRED_W'(fifo_count) + CRED_W'(fifo_push) + CRED_W'(ram_rden);
        for (int i = 0; i < int'(RD_LAT) - 1; i++) begin
            outstanding = outstanding + CRED_W'(pipe_v[i]);
        end
        outstanding = outstanding - CRED_W'(fifo_pop);
        can_issue   = (outstanding < CRED_W'(FIFO_DEPTH));
    end

    // In-flight read tracker aligned with the RAM's read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_v <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                pipe_id[i] <= '0;
            end
        end else begin
            pipe_v     <= {pipe_v[RD_LAT-2:0], ram_rden};
            pipe_id[0] <= ram_address;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                pipe_id[i] <= pipe_id[i-1];
            end
        end
    end

    // Pass sequencer with registered RAM controls and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            n_count     <= '0;
            next_addr   <= '0;
            ram_address <= '0;
            ram_rden    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            count_err   <= 1'b0;
        end else begin
            ram_rden <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= RD_CNT;
                        busy        <= 1'b1;
                        count_err   <= 1'b0;
                        ram_rden    <= 1'b1;
                        ram_address <= '0;
                    end
                end
                RD_CNT: begin
                    state <= WAIT_CNT;
                end
                WAIT_CNT: begin
                    if (pipe_v[RD_LAT-1]) begin
                        n_count   <= n_latch;
                        count_err <= cnt_over;
                        if (n_latch == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            // First particle issues alongside the count latch; pipe is empty.
                            ram_rden    <= 1'b1;
                            ram_address <= ADDR_WIDTH'(1);
                            next_addr   <= ADDR_WIDTH'(2);
                            state       <= (n_latch == ADDR_WIDTH'(1)) ? DRAIN : STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (can_issue) begin
                        ram_rden    <= 1'b1;
                        ram_address <= next_addr;
                        next_addr   <= next_addr + ADDR_WIDTH'(1);
                        if (next_addr == n_count) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pipe_empty &&
                        ((fifo_count == '0) || ((fifo_count == FCNT_W'(1)) && fifo_pop))) begin
                        state <= FIN;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    pos_out_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (FCNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .valid     (fifo_valid),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_cell_pos_reader.sv
// Directed passes with randomized RAM contents and ready patterns, checked
// against a list-of-particles reference built from the RAM image.
module tb_cell_pos_reader;

    localparam int unsigned DW = 96;
    localparam int unsigned AW = 8;
    localparam int unsigned PN = 220;
    localparam int unsigned FD = 4;
    localparam int unsigned BW = DW + AW + 1;

    typedef logic [BW-1:0] beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          count_err;
    logic [AW-1:0] ram_address;
    logic          ram_rden;
    logic          ram_wren;
    logic [DW-1:0] ram_q;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_id;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;

    cell_pos_reader #(
        .DATA_WIDTH   (DW),
        .PARTICLE_NUM (PN),
        .ADDR_WIDTH   (AW),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .count_err   (count_err),
        .ram_address (ram_address),
        .ram_rden    (ram_rden),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q),
        .out_data    (out_data),
        .out_id      (out_id),
        .out_last    (out_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    // RAM model: address/rden registered, data two cycles after the rden cycle.
    logic [DW-1:0] mem [PN];
    logic [AW-1:0] r1_addr;
    logic          r1_v;
    always @(posedge clk) begin
        r1_v    <= ram_rden;
        r1_addr <= ram_address;
        if (r1_v) ram_q <= mem[r1_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Observation statistics, cleared by the stimulus before each pass.
    int    rd_cnt, occ, max_occ, valid_seen, stall_bad, done_cnt;
    int    done_cyc, first_valid, first_acc, last_acc;
    bit    prev_stall;
    beat_t prev_beat;
    beat_t got_q[$];

    int errors = 0;
    int checks = 0;

    always @(negedge clk) begin
        beat_t cur;
        cur = {out_data, out_id, out_last};
        if (ram_rden) begin
            rd_cnt++;
            if (ram_address != '0) occ++;
        end
        if (occ > max_occ) max_occ = occ;
        if (out_valid) valid_seen++;
        if (out_valid && first_valid < 0) first_valid = cyc;
        if (prev_stall && (!out_valid || cur != prev_beat)) stall_bad++;
        prev_stall = out_valid && !out_ready;
        prev_beat  = cur;
        if (out_valid && out_ready) begin
            got_q.push_back(cur);
            occ--;
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        rd_cnt = 0; occ = 0; max_occ = 0; valid_seen = 0; stall_bad = 0; done_cnt = 0;
        done_cyc = -1; first_valid = -1; first_acc = -1; last_acc = -1;
        prev_stall = 1'b0; prev_beat = '0;
        got_q.delete();
    endtask

    task automatic fill_mem(input logic [7:0] cnt);
        logic [DW-1:0] w;
        for (int i = 0; i < int'(PN); i++) mem[i] = {$urandom, $urandom, $urandom};
        w = {$urandom, $urandom, $urandom};
        w[7:0] = cnt;
        mem[0] = w;
    endtask

    // mode 0: ready held high, 1: one cycle on / three off, 2: random.
    task automatic run_pass(input logic [7:0] cnt, input int mode, input bit extra);
        int    n;
        bit    exp_err;
        bit    got_done;
        bit    ex_done;
        int    start_cyc;
        beat_t exp_b;
        fill_mem(cnt);
        n       = (int'(cnt) > int'(PN) - 1) ? int'(PN) - 1 : int'(cnt);
        exp_err = (int'(cnt) > int'(PN) - 1);
        @(posedge clk); #1;
        clear_stats();
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 128'(busy), 128'(1));
        check("err_cleared_on_start", 128'(count_err), 128'(0));
        got_done = 1'b0;
        ex_done  = 1'b0;
        for (int t = 0; t < 4000 && !got_done; t++) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 4 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (extra && !ex_done && got_q.size() >= 2) begin
                start   = 1'b1;
                ex_done = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
                check("busy_low_at_done", 128'(busy), 128'(0));
            end
            @(posedge clk); #1;
        end
        start     = 1'b0;
        out_ready = 1'b0;
        check("done_seen", 128'(got_done), 128'(1));
        repeat (3) @(posedge clk);
        #1;
        check("done_pulses", 128'(done_cnt), 128'(1));
        check("beat_count", 128'(got_q.size()), 128'(n));
        for (int i = 1; i <= n && i <= got_q.size(); i++) begin
            exp_b = {mem[i], AW'(i), (i == n)};
            check($sformatf("beat_%0d", i), 128'(got_q[i-1]), 128'(exp_b));
        end
        check("count_err", 128'(count_err), 128'(exp_err));
        check("ram_reads", 128'(rd_cnt), 128'(n + 1));
        check("credit_le_depth", 128'(max_occ <= int'(FD)), 128'(1));
        check("stable_while_stalled", 128'(stall_bad), 128'(0));
        if (n > 0) begin
            check("done_after_last", 128'(done_cyc), 128'(last_acc + 1));
        end else begin
            check("no_valid_for_zero", 128'(valid_seen), 128'(0));
        end
        if (mode == 0 && n > 0) begin
            check("first_valid_latency", 128'((first_valid - start_cyc - 1) <= 6), 128'(1));
            check("back_to_back", 128'(last_acc - first_acc), 128'(n - 1));
        end
    endtask

    initial begin
        bit hit;
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        fill_mem(8'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_err", 128'(count_err), 128'(0));
        check("rst_rden", 128'(ram_rden), 128'(0));
        check("rst_addr", 128'(ram_address), 128'(0));
        check("rst_valid", 128'(out_valid), 128'(0));
        check("wren_tied", 128'(ram_wren), 128'(0));
        rst = 1'b0;

        run_pass(8'd5, 0, 1'b0);
        run_pass(8'd0, 0, 1'b0);
        run_pass(8'd219, 1, 1'b0);
        run_pass(8'd250, 0, 1'b0);
        run_pass(8'($urandom_range(1, 219)), 2, 1'b0);
        run_pass(8'd12, 0, 1'b1);

        // Abort mid-pass with reads in flight.
        fill_mem(8'd10);
        @(posedge clk); #1;
        clear_stats();
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hit   = 1'b0;
        for (int t = 0; t < 50 && !hit; t++) begin
            @(negedge clk);
            if (ram_rden && ram_address == AW'(4)) hit = 1'b1;
        end
        check("saw_issue_id4", 128'(hit), 128'(1));
        rst = 1'b1;
        #1;
        check("abort_rden", 128'(ram_rden), 128'(0));
        check("abort_addr", 128'(ram_address), 128'(0));
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_valid", 128'(out_valid), 128'(0));
        check("abort_id", 128'(out_id), 128'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        clear_stats();
        repeat (8) @(posedge clk);
        #1;
        check("no_stray_valid", 128'(valid_seen), 128'(0));
        check("no_done_after_abort", 128'(done_cnt), 128'(0));
        check("no_reads_after_abort", 128'(rd_cnt), 128'(0));
        run_pass(8'd10, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
